seg_scan_driver: RTL and testbench

- Time-multiplexed scan controller for a common-bus multi-digit seven-segment display.
- Sits directly upstream of the per-digit hex-to-segment decoder.
- Holds a snapshot of the display word and presents one 4-bit nibble at a time on data_disp, which feeds the decoder input, together with a one-hot digit select and a decimal-point bit.
- Inserts a blanking gap between digits to suppress ghosting.

---
 rtl/seg_scan_driver.sv | 131 +++++++++++++
 tb/tb_seg_scan_driver.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan controller for a common-bus seven-segment display.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_driver #(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   disp_data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic [3:0]            data_disp,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  dp_out,
  output logic [2:0]            digit_idx
);

  localparam int             CW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [2:0]     IDX_LAST   = 3'(DIGITS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [4*DIGITS-1:0] shadow_data_q, shadow_data_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [0:0]          state_q, state_d;
  logic [3:0]          data_disp_q, data_disp_d;
  logic [DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic                dp_out_q, dp_out_d;
  logic                cur_dp_q, cur_dp_d;
  logic                cur_show_q, cur_show_d;
  logic                fresh_q;

  logic                tick, period_start;
  logic [DIGITS-1:0]   show_mask;
  logic [3:0]          nib_next;
  logic                dp_next, show_next;

  // A digit is suppressed when it and every digit above it carry nothing visible.
  always_comb begin
`ifdef SEG_SCAN_LZB_EN
    logic seen;
    seen      = 1'b0;
    show_mask = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      seen         = seen | (shadow_data_q[4*k +: 4] != 4'd0) | shadow_dp_q[k];
      show_mask[k] = seen | (k == 0);
    end
`else
    show_mask = '1;
`endif
  end

  always_comb begin
    tick         = (cnt_q == CNT_LAST);
    period_start = tick | fresh_q;
    cnt_d        = tick ? '0 : cnt_q + CW'(1);
    idx_d        = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;

    state_d = state_q;
    if (BLANK_CYC == 0)                                  state_d = ST_SHOW;
    else if (tick)                                       state_d = ST_BLANK;
    else if (state_q == ST_BLANK && cnt_q == BLANK_LAST) state_d = ST_SHOW;

    shadow_data_d = load ? disp_data : shadow_data_q;
    shadow_dp_d   = load ? dp_in     : shadow_dp_q;

    nib_next  = 4'd0;
    dp_next   = 1'b0;
    show_next = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_d == 3'(k)) begin
        nib_next  = shadow_data_q[4*k +: 4];
        dp_next   = shadow_dp_q[k];
        show_next = show_mask[k];
      end
    end

    // Per-digit content is frozen at the period start so nothing flickers mid-period.
    data_disp_d = period_start ? nib_next  : data_disp_q;
    cur_dp_d    = period_start ? dp_next   : cur_dp_q;
    cur_show_d  = period_start ? show_next : cur_show_q;

    digit_sel_d = '0;
    if (state_d == ST_SHOW && cur_show_d) begin
      for (int k = 0; k < DIGITS; k++)
        if (idx_d == 3'(k)) digit_sel_d[k] = 1'b1;
    end
    dp_out_d = (state_d == ST_SHOW) & cur_show_d & cur_dp_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      cnt_q         <= '0;
      idx_q         <= 3'd0;
      state_q       <= ST_BLANK;
      data_disp_q   <= 4'd0;
      digit_sel_q   <= '0;
      dp_out_q      <= 1'b0;
      cur_dp_q      <= 1'b0;
      cur_show_q    <= 1'b0;
      fresh_q       <= 1'b1;
    end else begin
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      state_q       <= state_d;
      data_disp_q   <= data_disp_d;
      digit_sel_q   <= digit_sel_d;
      dp_out_q      <= dp_out_d;
      cur_dp_q      <= cur_dp_d;
      cur_show_q    <= cur_show_d;
      fresh_q       <= 1'b0;
    end
  end

  assign data_disp = data_disp_q;
  assign digit_sel = digit_sel_q;
  assign dp_out    = dp_out_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench: two 4-digit scanners (blank gap of 2 and of 0 cycles) share one stimulus.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] disp_data;
  logic [3:0]  dp_in;
  logic        load;

  logic [3:0] disp_a, disp_b, sel_a, sel_b;
  logic [2:0] idx_a, idx_b;
  logic       dp_a, dp_b;

`ifdef SEG_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  seg_scan_driver #(.DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2)) u_a (
    .clk(clk), .rst(rst), .disp_data(disp_data), .dp_in(dp_in), .load(load),
    .data_disp(disp_a), .digit_sel(sel_a), .dp_out(dp_a), .digit_idx(idx_a));

  seg_scan_driver #(.DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(0)) u_b (
    .clk(clk), .rst(rst), .disp_data(disp_data), .dp_in(dp_in), .load(load),
    .data_disp(disp_b), .digit_sel(sel_b), .dp_out(dp_b), .digit_idx(idx_b));

  always #5 clk = ~clk;

  typedef struct {
    int t;
    int disp;
    int sel_a;
    int dp_a;
    int sel_b;
    int dp_b;
    int idx;
  } vec_t;

  vec_t tbl[15];
  int   errors = 0;
  int   checks = 0;
  int   t      = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic goto(input int tt);
    while (t < tt) adv();
  endtask

  task automatic chk_a(input string tag, input int disp, input int sel, input int dp, input int idx);
    chk({tag, ".a.disp"}, int'(disp_a), disp);
    chk({tag, ".a.sel"},  int'(sel_a),  sel);
    chk({tag, ".a.dp"},   int'(dp_a),   dp);
    chk({tag, ".a.idx"},  int'(idx_a),  idx);
  endtask

  task automatic chk_b(input string tag, input int disp, input int sel, input int dp, input int idx);
    chk({tag, ".b.disp"}, int'(disp_b), disp);
    chk({tag, ".b.sel"},  int'(sel_b),  sel);
    chk({tag, ".b.dp"},   int'(dp_b),   dp);
    chk({tag, ".b.idx"},  int'(idx_b),  idx);
  endtask

  initial begin
    //            t disp selA dpA selB dpB idx
    tbl[0]  = '{ 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{ 1, 0, 0, 0, 1, 0, 0};
    tbl[2]  = '{ 2, 0, 1, 0, 1, 0, 0};
    tbl[3]  = '{ 7, 0, 1, 0, 1, 0, 0};
    tbl[4]  = '{ 8, 3, 0, 0, 2, 0, 1};
    tbl[5]  = '{10, 3, 2, 0, 2, 0, 1};
    tbl[6]  = '{15, 3, 2, 0, 2, 0, 1};
    tbl[7]  = '{16, 2, 0, 0, 4, 1, 2};
    tbl[8]  = '{18, 2, 4, 1, 4, 1, 2};
    tbl[9]  = '{23, 2, 4, 1, 4, 1, 2};
    tbl[10] = '{24, 1, 0, 0, 8, 0, 3};
    tbl[11] = '{26, 1, 8, 0, 8, 0, 3};
    tbl[12] = '{31, 1, 8, 0, 8, 0, 3};
    tbl[13] = '{32, 4, 0, 0, 1, 0, 0};
    tbl[14] = '{34, 4, 1, 0, 1, 0, 0};

    // Reset with a conflicting load: the load must be ignored.
    rst = 1'b1; load = 1'b1; disp_data = 16'hFFFF; dp_in = 4'hF;
    adv(); adv();
    load = 1'b0;
    adv();
    chk_a("reset", 0, 0, 0, 0);
    chk_b("reset", 0, 0, 0, 0);

    // Release and load 1234 on the first edge; digit 0 still shows the cleared shadow.
    rst = 1'b0; load = 1'b1; disp_data = 16'h1234; dp_in = 4'b0100;
    t = 0;
    for (int i = 0; i < 15; i++) begin
      while (t < tbl[i].t) begin
        adv();
        load = 1'b0;
      end
      chk_a($sformatf("scan%0d", tbl[i].t), tbl[i].disp, tbl[i].sel_a, tbl[i].dp_a, tbl[i].idx);
      chk_b($sformatf("scan%0d", tbl[i].t), tbl[i].disp, tbl[i].sel_b, tbl[i].dp_b, tbl[i].idx);
    end

    // Mid-period load during digit 1: current digit keeps its nibble.
    goto(42);
    load = 1'b1; disp_data = 16'hABCD; dp_in = 4'b0100;
    adv();
    load = 1'b0;
    chk_a("midload43", 3, 2, 0, 1);
    goto(47);
    chk_a("midload47", 3, 2, 0, 1);
    goto(48);
    chk_a("midload48", 11, 0, 0, 2);
    chk_b("midload48", 11, 4, 1, 2);
    goto(50);
    chk_a("midload50", 11, 4, 1, 2);

    // Reset in the SHOW phase of digit 2.
    rst = 1'b1;
    adv();
    chk_a("midrst", 0, 0, 0, 0);
    chk_b("midrst", 0, 0, 0, 0);
    adv(); adv();
    rst = 1'b0;
    t = 0;
    adv();
    chk_a("rel1", 0, 0, 0, 0);
    chk_b("rel1", 0, 1, 0, 0);
    adv();
    chk_a("rel2", 0, 1, 0, 0);

    // Leading-zero pattern 0050, then all zeros.
    goto(3);
    load = 1'b1; disp_data = 16'h0050; dp_in = 4'b0000;
    adv();
    load = 1'b0;
    goto(10);
    chk_a("lz10", 5, 2, 0, 1);
    chk_b("lz10", 5, 2, 0, 1);
    goto(18);
    chk_a("lz18", 0, LZB ? 0 : 4, 0, 2);
    chk_b("lz18", 0, LZB ? 0 : 4, 0, 2);
    goto(26);
    chk_a("lz26", 0, LZB ? 0 : 8, 0, 3);
    chk_b("lz26", 0, LZB ? 0 : 8, 0, 3);
    goto(34);
    chk_a("lz34", 0, 1, 0, 0);
    goto(35);
    load = 1'b1; disp_data = 16'h0000;
    adv();
    load = 1'b0;
    goto(42);
    chk_a("zero42", 0, LZB ? 0 : 2, 0, 1);
    chk_b("zero42", 0, LZB ? 0 : 2, 0, 1);
    goto(66);
    chk_a("zero66", 0, 1, 0, 0);
    chk_b("zero66", 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
